// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_pkg
// Purpose : Shared types and constants for the PS/2 receive controller.
// Revision: 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic ADR_DATA   = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    localparam int STAT_READY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_PERR  = 3;
    localparam int STAT_FERR  = 4;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ps2_sync_fifo
// Purpose : Single-clock FIFO; push and pop may coincide at any occupancy.
// Revision: 1.0
// ============================================================================
module ps2_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot the simultaneous push lands in when full.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ps2_rx_ctrl
// Purpose : PS/2 device-to-host receiver with FIFO and DATA/STATUS bus regs.
// Revision: 1.0
// ============================================================================
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic       adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       ready,
    output logic       irq_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall_w;

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic          push_q;
    logic [7:0]    push_data_q;
    logic          ferr_ev_q;
    logic          perr_ev_q;

    logic          ovf_q, perr_q, ferr_q;
    logic          ack_q;
    logic [7:0]    dat_o_q;

    logic          access_w, pop_w, clr_w, ovf_set_w;
    logic [7:0]    fifo_head;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic [7:0]    status_w;
    logic          unused_dat;

    // Synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clock;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall_w = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            ferr_ev_q   <= 1'b0;
            perr_ev_q   <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            ferr_ev_q <= 1'b0;
            perr_ev_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                tmo_q <= '0;
                if (fall_w && !dat_s2_q) begin
                    state_q   <= ST_DATA;
                    bit_cnt_q <= 3'd0;
                    shift_q   <= 8'h00;
                end
            end else if (!fall_w) begin
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q   <= ST_IDLE;
                    ferr_ev_q <= 1'b1;
                    tmo_q     <= '0;
                    bit_cnt_q <= 3'd0;
                    shift_q   <= 8'h00;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                tmo_q <= '0;
                case (state_q)
                    ST_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        parity_q <= dat_s2_q;
                        state_q  <= ST_STOP;
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        ferr_ev_q   <= ~dat_s2_q;
                        perr_ev_q   <= ~odd_parity_ok(shift_q, parity_q);
                        push_q      <= dat_s2_q & odd_parity_ok(shift_q, parity_q);
                        push_data_q <= shift_q;
                    end
                endcase
            end
        end
    end

    ps2_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_q),
        .wdata_i (push_data_q),
        .pop_i   (pop_w),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign access_w  = cyc_i & stb_i & ~ack_q;
    assign pop_w     = access_w & ~we_i & (adr_i == ADR_DATA) & ~fifo_empty;
    assign clr_w     = access_w & we_i & (adr_i == ADR_STATUS);
    assign ovf_set_w = push_q & fifo_full & ~pop_w;
    assign status_w  = {3'b000, ferr_q, perr_q, ovf_q, fifo_full, ready};
    assign unused_dat = ^{dat_i[7:5], dat_i[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            dat_o_q <= 8'h00;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ack_q <= access_w;
            if (access_w && !we_i) begin
                if (adr_i == ADR_DATA) dat_o_q <= fifo_empty ? 8'h00 : fifo_head;
                else                   dat_o_q <= status_w;
            end
            // A set event in the same cycle as a clear keeps the flag.
            ovf_q  <= ovf_set_w | (ovf_q  & ~(clr_w & dat_i[STAT_OVF]));
            perr_q <= perr_ev_q | (perr_q & ~(clr_w & dat_i[STAT_PERR]));
            ferr_q <= ferr_ev_q | (ferr_q & ~(clr_w & dat_i[STAT_FERR]));
        end
    end

    assign ready = (fifo_count != '0);
    assign irq_o = ready | ovf_q | perr_q | ferr_q;
    assign dat_o = dat_o_q;
    assign ack_o = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_rx_ctrl
// Purpose : Directed scoreboard bench for ps2_rx_ctrl.
// Revision: 1.0
// ============================================================================
module tb_ps2_rx_ctrl;
    import ps2_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 400;
    localparam int H     = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
    logic [7:0] wdat = 8'h00;
    logic [7:0] rdat;
    logic       ack, rdy, irq;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    bit         m_ovf = 0, m_perr = 0, m_ferr = 0;
    logic [7:0] d;
    int         acks;

    ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .ps2_clock(ps2c), .ps2_data(ps2d),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(wdat),
        .dat_o(rdat), .ack_o(ack), .ready(rdy), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {3'b000, m_ferr, m_perr, m_ovf, sb.size() == DEPTH, sb.size() != 0};
    endfunction

    task automatic ps2_bit(input logic b, input bit hold_low);
        @(negedge clk);
        ps2d = b;
        repeat (H) @(negedge clk);
        ps2c = 1'b0;
        if (!hold_low) begin
            repeat (H) @(negedge clk);
            ps2c = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit hold, input bit upd);
        logic [FRAME_BITS-1:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < FRAME_BITS; i++) ps2_bit(f[i], hold && (i == FRAME_BITS - 1));
        if (upd && !bad_par && !bad_stop) begin
            if (sb.size() < DEPTH) sb.push_back(b);
            else                   m_ovf = 1;
        end
        if (bad_par)  m_perr = 1;
        if (bad_stop) m_ferr = 1;
        if (!hold) begin
            ps2d = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic bus_xfer(input logic w, input logic a, input logic [7:0] v,
                            output logic [7:0] r);
        bit got;
        got = 0;
        r = 8'hxx;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = v;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1;
                r = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("bus_ack", {7'b0, got}, 8'h01);
    endtask

    task automatic read_status(input string tag);
        logic [7:0] r;
        bus_xfer(1'b0, ADR_STATUS, 8'h00, r);
        check(tag, r, exp_status());
    endtask

    task automatic read_data(input string tag);
        logic [7:0] r, e;
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        bus_xfer(1'b0, ADR_DATA, 8'h00, r);
        check(tag, r, e);
    endtask

    task automatic write_reg(input logic a, input logic [7:0] v);
        logic [7:0] r;
        bus_xfer(1'b1, a, v, r);
        if (a == ADR_STATUS) begin
            if (v[STAT_OVF])  m_ovf  = 0;
            if (v[STAT_PERR]) m_perr = 0;
            if (v[STAT_FERR]) m_ferr = 0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {7'b0, rdy}, 8'h00);
        check("rst_irq",   {7'b0, irq}, 8'h00);
        check("rst_ack",   {7'b0, ack}, 8'h00);
        check("rst_dat_o", rdat, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        read_status("rst_status");
        read_data("empty_read");
        read_status("empty_read_status");

        // Valid frame, ready latency, read pops
        send_frame(8'h1C, 0, 0, 1, 1);
        for (int i = 0; i < 5 && !rdy; i++) begin
            @(posedge clk); #1;
        end
        check("ready_latency", {7'b0, rdy}, 8'h01);
        @(negedge clk); ps2c = 1'b1; ps2d = 1'b1;
        repeat (4) @(negedge clk);
        read_data("rx_1c");
        check("ready_after_pop", {7'b0, rdy}, 8'h00);

        // Parity / framing errors and clearing
        send_frame(8'h1C, 1, 0, 0, 1);
        read_status("perr_status");
        check("perr_irq", {7'b0, irq}, 8'h01);
        write_reg(ADR_STATUS, 8'h08);
        read_status("perr_cleared");
        check("perr_irq_clear", {7'b0, irq}, 8'h00);
        send_frame(8'hA5, 0, 1, 0, 1);
        read_status("ferr_status");
        send_frame(8'h3C, 1, 1, 0, 1);
        read_status("both_err_status");
        write_reg(ADR_STATUS, 8'h1C);
        read_status("all_cleared");

        // Overflow: DEPTH+1 frames
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 0, 0, 0, 1);
        read_status("ovf_status");
        for (int i = 0; i < DEPTH; i++) read_data("ovf_drain");
        read_status("ovf_after_drain");
        write_reg(ADR_STATUS, 8'h04);
        check("irq_idle", {7'b0, irq}, 8'h00);

        // Pop coinciding with push while full
        for (int i = 0; i < DEPTH; i++) send_frame(8'h20 + 8'(i), 0, 0, 0, 1);
        read_status("full_status");
        send_frame(8'h55, 0, 0, 1, 0);
        repeat (3) @(posedge clk);
        read_data("coincide_rd");
        sb.push_back(8'h55);
        @(negedge clk); ps2c = 1'b1; ps2d = 1'b1;
        repeat (4) @(negedge clk);
        read_status("coincide_status");
        for (int i = 0; i < DEPTH; i++) read_data("coincide_drain");

        // Held strobe acks every other cycle
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = ADR_STATUS;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            acks += int'(ack);
        end
        cyc = 1'b0; stb = 1'b0;
        check("held_strobe_acks", 8'(acks), 8'd3);

        // Timeout on a partial frame
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0); ps2_bit(1'b0, 0); ps2_bit(1'b1, 0); ps2_bit(1'b1, 0);
        ps2d = 1'b1;
        repeat (TMO + 2) @(posedge clk);
        m_ferr = 1;
        read_status("timeout_status");
        write_reg(ADR_STATUS, 8'h10);
        send_frame(8'h5A, 0, 0, 0, 1);
        read_status("post_timeout_status");
        read_data("rx_5a");

        // Reset mid-frame discards partial frame and FIFO contents
        send_frame(8'h33, 0, 0, 0, 1);
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_ready", {7'b0, rdy}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_ovf = 0; m_perr = 0; m_ferr = 0;
        send_frame(8'hF0, 0, 0, 0, 1);
        read_status("post_rst_status");
        write_reg(ADR_DATA, 8'hFF);
        read_status("write_data_noeffect");
        read_data("rx_f0");
        read_status("final_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16; receive FIFO entries, power of two, 2..256.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000; clk_i cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clk_i  in  1  system clock, all logic rising-edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_clock  in  1  raw PS/2 clock, asynchronous.
REQ-006 SHALL have port ps2_data  in  1  raw PS/2 data, asynchronous.
REQ-007 SHALL have port cyc_i, stb_i, we_i  in  1 each  bus cycle, strobe, write enable.
REQ-008 SHALL have port adr_i  in  1  register select: 0=DATA, 1=STATUS.
REQ-009 SHALL have port dat_i  in  8  write data.
REQ-010 SHALL have port dat_o  out  8  registered read data.
REQ-011 SHALL have port ack_o  out  1  bus acknowledge.
REQ-012 SHALL have port ready  out  1  FIFO not empty.
REQ-013 SHALL have port irq_o  out  1  level interrupt.

Function
REQ-014 SHALL pass ps2_clock and ps2_data through 2-flop synchronisers; falling edge = previous synced clock 1, current 0.
REQ-015 SHALL implement FSM IDLE, DATA, PARITY, STOP, advancing only on synced falling edges.
REQ-016 IDLE: sampled data 0 -> DATA with bit count 0; sampled 1 -> stay IDLE, no flag.
REQ-017 DATA: shift sampled bit in LSB-first; after 8th bit -> PARITY.
REQ-018 PARITY: store bit -> STOP; odd parity required over 8 data bits plus parity.
REQ-019 STOP: always -> IDLE; stop=0 sets FERR, drops byte; parity wrong sets PERR, drops byte; both wrong sets both.
REQ-020 Valid frame SHALL push byte into FIFO the cycle after the stop-bit edge.
REQ-021 Push while full with no same-cycle pop SHALL drop byte, set OVF; FIFO contents unchanged.
REQ-022 Push and pop in same cycle SHALL both succeed at any occupancy, including full.
REQ-023 In DATA/PARITY/STOP, TIMEOUT_CYCLES cycles with no falling edge SHALL force IDLE, set FERR, discard partial byte; counter clears on every edge and in IDLE.
REQ-024 ack_o SHALL assert the cycle after cyc_i&stb_i is sampled high with ack_o low, for exactly one cycle; held strobe yields ack every other cycle.
REQ-025 Read DATA (adr_i=0) SHALL present FIFO head on dat_o with ack_o and pop once; if empty, dat_o=0x00, no pop, no flag.
REQ-026 Read STATUS SHALL return {3'b0, FERR, PERR, OVF, full, ready}, bit0=ready.
REQ-027 Write STATUS SHALL clear each sticky flag whose dat_i bit (2..4) is 1; a same-cycle set event wins over clear.
REQ-028 Write DATA SHALL be acked, no effect.
REQ-029 ready SHALL be high iff FIFO occupancy > 0; irq_o = ready | OVF | PERR | FERR.
REQ-030 Occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits; pointers log2(FIFO_DEPTH) bits wrapping modulo depth.

Reset
REQ-031 rst_i SHALL asynchronously force: FSM IDLE, bit counter 0, shift reg 0, synchronisers 1 (idle bus), timeout counter 0, FIFO empty, pointers 0, OVF/PERR/FERR 0, dat_o 0x00, ack_o 0, ready 0, irq_o 0.
REQ-032 Reset mid-frame SHALL discard partial frame; reception resumes at next start bit after release.

Structure
REQ-033 Shared package ps2_pkg SHALL hold FSM state type, register addresses, STATUS bit indices, frame length constant 11.
REQ-034 FIFO SHALL be sub-module ps2_sync_fifo (parameter DEPTH, WIDTH=8), single clock, with push, pop, empty, full, count.

Verification
REQ-035 Frame 0x1C, odd parity 0, stop 1 -> ready=1 within 3 cycles after stop edge; DATA read returns 0x1C, ready=0.
REQ-036 Frame 0x1C with parity bit 1 -> FIFO empty, STATUS=0x08, irq_o=1; write STATUS 0x08 -> STATUS=0x00, irq_o=0.
REQ-037 FIFO_DEPTH+1 valid frames 0x01..0x11, no reads -> STATUS=0x07; 16 reads return 0x01..0x10 in order.
REQ-038 Start, 4 data bits, then idle TIMEOUT_CYCLES+2 cycles -> FSM IDLE, STATUS=0x10; following frame 0x5A received correctly.
REQ-039 rst_i pulse after 5th data bit, then full frame 0xF0 -> only 0xF0 in FIFO, STATUS=0x01.
REQ-040 Full FIFO, DATA read whose pop coincides with a new valid push -> no OVF, count stays FIFO_DEPTH, new byte last out.
